dac_spi_driver: RTL and testbench
=================================

# dac_spi_driver

Serialises the 12-bit waveform samples produced by the amplitude/phase compute stage into 16-bit SPI frames for an external 12-bit DAC (MCP4921-style, SPI mode 0). Sits directly downstream of the compute stage and is the last block before the board pins. It accepts one sample per frame through a valid/ready handshake, prepends a 4-bit DAC command nibble, and generates CS, SCLK and MOSI with programmable bit rate and inter-frame gap.

## Interface
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255
- GAP_CYCLES, 2, clk cycles cs_n stays high after a frame before the next sample is accepted; legal range 1..255
- CONFIG, 4'b0011, command nibble sent as frame bits [15:12] (A/B, BUF, GA_n, SHDN_n)

- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- sample_in  input  12  unsigned DAC code from the compute stage
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  block accepts sample_in on this cycle when sample_valid is high
- dac_cs_n  output  1  DAC chip select, active low
- dac_sclk  output  1  SPI clock, idle low
- dac_mosi  output  1  serial data, MSB first
- frame_done  output  1  one-cycle pulse when cs_n returns high after a complete frame

## Operation
- Reset is synchronous, active-high, on clock clk. All outputs registered. Reset values: dac_cs_n=1, dac_sclk=0, dac_mosi=0, sample_ready=1, frame_done=0; state=IDLE; counters cleared.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE: sample_ready=1, cs_n=1, sclk=0. On a clock edge with sample_valid && sample_ready: latch frame = {CONFIG, sample_in}, bit counter=15, go to SHIFT. sample_in is ignored when not accepted.
- SHIFT: each bit takes 2*CLK_DIV cycles: CLK_DIV cycles sclk=0 with mosi=frame[bit], then CLK_DIV cycles sclk=1. mosi changes only while sclk is low (on the sclk falling edge or at frame start). After the high half of bit 0, sclk=0 and go to HOLD.
- HOLD: cs_n=0, sclk=0 for CLK_DIV cycles (CS hold time), then cs_n=1, frame_done pulses, go to GAP.
- GAP: cs_n=1 for GAP_CYCLES cycles, then sample_ready=1, return to IDLE.
- sample_ready is 0 in SHIFT, HOLD and GAP; no buffering, upstream must hold sample_valid/sample_in until accepted.
- Reset mid-frame: outputs return to reset values on the next edge; the partial frame is abandoned (cs_n rises with fewer than 16 SCLK rises, DAC discards it); frame_done does not pulse.
- sample_valid asserted during reset is not accepted; first acceptance possible on the first edge after reset deasserts.

## Timing
- Acceptance edge = T0. At T0+1: cs_n=0, sclk=0, mosi=frame[15], sample_ready=0.
- k-th SCLK rise (k=1..16) at T0+1+(2k-1)*CLK_DIV; k-th fall at T0+1+2k*CLK_DIV.
- cs_n=1 and frame_done=1 at T0+1+33*CLK_DIV; frame_done low the following cycle.
- sample_ready=1 at T0+1+33*CLK_DIV+GAP_CYCLES; earliest next acceptance on that cycle.
- Frame period = 1+33*CLK_DIV+GAP_CYCLES cycles (69 for defaults); exactly 16 SCLK rises per frame.
- Back-to-back: sample_valid held high gives continuous frames at that period with no extra bubbles.

## Test plan
- Reset then sample_in=12'hABC, valid for one cycle (defaults) -> cs_n low at T0+1; MOSI sampled on the 16 SCLK rises = 16'h3ABC; cs_n high and frame_done at T0+67; sample_ready at T0+69.
- valid held high with samples 12'h000, 12'hFFF, 12'h800 -> three frames 16'h3000, 16'h3FFF, 16'h3800, accepts exactly 69 cycles apart, none lost or duplicated.
- CLK_DIV=1, GAP_CYCLES=1 -> SCLK toggles every cycle, frame period 35 cycles, 16 rises per frame.
- sample_valid toggling while busy with changing sample_in -> frame content equals value latched at T0; ready stays 0 until T0+69.
- reset asserted at T0+20 mid-frame -> next cycle cs_n=1, sclk=0, mosi=0, sample_ready=1, no frame_done; new sample after reset produces a complete correct frame.
- CONFIG=4'b1111, sample 12'h555 -> MOSI frame 16'hF555; cs_n never low while in IDLE or GAP.

Source files
------------

// File: rtl/dac_spi_driver.sv
// SPI mode-0 serialiser for a 12-bit DAC: sends {CONFIG, sample} as a 16-bit frame, MSB first.
// One sample per frame via valid/ready; frame period is 1 + 33*CLK_DIV + GAP_CYCLES clocks.
module dac_spi_driver #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [3:0]  CONFIG     = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  // sclk_q doubles as the half-bit phase: low half presents data, high half lets the DAC sample it.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_valid && ready_q) begin
          state_d = SHIFT;
          frame_d = {CONFIG, sample_in};
          bit_d   = 4'd15;
          cnt_d   = '0;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = CONFIG[3];
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = frame_q[bit_q - 4'd1];
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sample_ready = ready_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench: default instance (A) and a fast CLK_DIV=1/GAP=1/CONFIG=F instance (B).
// Outputs sampled on the falling clock edge; frames reassembled from MOSI on SCLK rises.
module tb_dac_spi_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  logic        a_reset, a_valid, a_ready, a_cs_n, a_sclk, a_mosi, a_done;
  logic [11:0] a_sample;
  logic        b_reset, b_valid, b_ready, b_cs_n, b_sclk, b_mosi, b_done;
  logic [11:0] b_sample;

  dac_spi_driver u_a (
    .clk(clk), .reset(a_reset), .sample_in(a_sample), .sample_valid(a_valid),
    .sample_ready(a_ready), .dac_cs_n(a_cs_n), .dac_sclk(a_sclk), .dac_mosi(a_mosi),
    .frame_done(a_done)
  );

  dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(1), .CONFIG(4'b1111)) u_b (
    .clk(clk), .reset(b_reset), .sample_in(b_sample), .sample_valid(b_valid),
    .sample_ready(b_ready), .dac_cs_n(b_cs_n), .dac_sclk(b_sclk), .dac_mosi(b_mosi),
    .frame_done(b_done)
  );

  typedef struct {
    logic [15:0] dat;
    int          rises;
    int          low;
    logic        done;
  } frec_t;

  frec_t fq_a[$];
  frec_t fq_b[$];
  int    aq_a[$];
  int    aq_b[$];

  // Frame capture for A: shift MOSI on each SCLK rise while cs_n is low, record on cs_n rise.
  logic [15:0] sh_a = '0;
  int          ri_a = 0, lo_a = 0;
  logic        pc_a = 1'b1, ps_a = 1'b0;
  initial forever begin
    @(negedge clk);
    if (a_cs_n === 1'b0 && pc_a === 1'b1) begin sh_a = '0; ri_a = 0; lo_a = 0; end
    if (a_cs_n === 1'b0) begin
      lo_a++;
      if (a_sclk === 1'b1 && ps_a === 1'b0) begin sh_a = {sh_a[14:0], a_mosi}; ri_a++; end
    end
    if (a_cs_n === 1'b1 && pc_a === 1'b0) fq_a.push_back('{sh_a, ri_a, lo_a, a_done});
    pc_a = a_cs_n;
    ps_a = a_sclk;
  end

  logic [15:0] sh_b = '0;
  int          ri_b = 0, lo_b = 0;
  logic        pc_b = 1'b1, ps_b = 1'b0;
  initial forever begin
    @(negedge clk);
    if (b_cs_n === 1'b0 && pc_b === 1'b1) begin sh_b = '0; ri_b = 0; lo_b = 0; end
    if (b_cs_n === 1'b0) begin
      lo_b++;
      if (b_sclk === 1'b1 && ps_b === 1'b0) begin sh_b = {sh_b[14:0], b_mosi}; ri_b++; end
    end
    if (b_cs_n === 1'b1 && pc_b === 1'b0) fq_b.push_back('{sh_b, ri_b, lo_b, b_done});
    pc_b = b_cs_n;
    ps_b = b_sclk;
  end

  // Handshake logger: records the cycle index of every accepted sample.
  initial forever begin
    @(posedge clk);
    if (a_reset === 1'b0 && a_valid === 1'b1 && a_ready === 1'b1) aq_a.push_back(cyc);
    if (b_reset === 1'b0 && b_valid === 1'b1 && b_ready === 1'b1) aq_b.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_rdy(input bit use_b, output int t0);
    int n;
    n = 0;
    while (((use_b ? b_ready : a_ready) !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_ready: ready never rose (got 0 want 1)");
    end
    t0 = cyc;
  endtask

  typedef struct {
    logic [11:0] smp;
    logic [15:0] frm;
  } vec_t;

  vec_t  vt[4];
  frec_t f;
  int    t0, t1, errs;
  int    acc[4];

  initial begin
    vt[0] = '{12'h000, 16'h3000};
    vt[1] = '{12'hFFF, 16'h3FFF};
    vt[2] = '{12'h800, 16'h3800};
    vt[3] = '{12'h001, 16'h3001};

    a_reset = 1'b1; a_valid = 1'b0; a_sample = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_sample = '0;
    step(3);
    chk("rst cs_n",  a_cs_n,  1);
    chk("rst sclk",  a_sclk,  0);
    chk("rst mosi",  a_mosi,  0);
    chk("rst ready", a_ready, 1);
    chk("rst done",  a_done,  0);
    chk("rst b cs_n", b_cs_n, 1);

    // Single frame 0xABC, accepted on the first edge after reset release.
    a_reset = 1'b0; b_reset = 1'b0;
    a_sample = 12'hABC; a_valid = 1'b1; t0 = cyc;
    step(1);
    a_valid = 1'b0; a_sample = 12'h000;
    chk("t1 cs_n",  a_cs_n,  0);
    chk("t1 sclk",  a_sclk,  0);
    chk("t1 mosi",  a_mosi,  0);
    chk("t1 ready", a_ready, 0);
    go_to(t0 + 3);  chk("first rise", a_sclk, 1);
    go_to(t0 + 5);  chk("first fall", a_sclk, 0);
    go_to(t0 + 66); chk("t66 cs_n", a_cs_n, 0);
    go_to(t0 + 67); chk("t67 cs_n", a_cs_n, 1); chk("t67 done", a_done, 1);
    go_to(t0 + 68); chk("t68 done", a_done, 0); chk("t68 ready", a_ready, 0);
    go_to(t0 + 69); chk("t69 ready", a_ready, 1);
    chk("abc nframes", fq_a.size(), 1);
    if (fq_a.size() > 0) begin
      f = fq_a.pop_front();
      chk("abc data", f.dat, 16'h3ABC);
      chk("abc rises", f.rises, 16);
      chk("abc cs low", f.low, 66);
      chk("abc done", f.done, 1);
    end

    // Back-to-back frames with valid held high.
    fq_a.delete(); aq_a.delete();
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_sample = vt[i].smp;
      wait_rdy(1'b0, acc[i]);
      step(1);
    end
    a_valid = 1'b0;
    go_to(acc[3] + 70);
    chk("b2b accepts", aq_a.size(), 4);
    chk("b2b frames", fq_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk($sformatf("b2b period %0d", i), acc[i] - acc[i-1], 69);
      if (fq_a.size() > 0) begin
        f = fq_a.pop_front();
        chk($sformatf("b2b data %0d", i), f.dat, vt[i].frm);
        chk($sformatf("b2b rises %0d", i), f.rises, 16);
      end
    end

    // Busy period with valid and sample_in toggling.
    fq_a.delete(); aq_a.delete();
    a_sample = 12'h123; a_valid = 1'b1;
    wait_rdy(1'b0, t0);
    errs = 0;
    for (int c = 1; c < 69; c++) begin
      step(1);
      if (c < 60) begin
        a_valid  = 1'($urandom_range(0, 1));
        a_sample = 12'($urandom);
      end else begin
        a_valid  = 1'b1;
        a_sample = 12'h456;
      end
      if (a_ready !== 1'b0) errs++;
    end
    chk("busy ready low", errs, 0);
    step(1);
    chk("busy ready t69", a_ready, 1);
    step(1);
    a_valid = 1'b0;
    go_to(t0 + 140);
    chk("busy accepts", aq_a.size(), 2);
    if (aq_a.size() == 2) chk("busy next accept", aq_a[1] - aq_a[0], 69);
    chk("busy frames", fq_a.size(), 2);
    if (fq_a.size() == 2) begin
      chk("busy frame0", fq_a[0].dat, 16'h3123);
      chk("busy frame1", fq_a[1].dat, 16'h3456);
    end

    // Reset in the middle of a frame, valid held during reset.
    fq_a.delete(); aq_a.delete();
    wait_rdy(1'b0, t0);
    a_sample = 12'h321; a_valid = 1'b1;
    step(1);
    a_valid = 1'b0;
    go_to(t0 + 20);
    a_reset = 1'b1; a_valid = 1'b1; a_sample = 12'h777;
    step(1);
    chk("mid rst cs_n",  a_cs_n,  1);
    chk("mid rst sclk",  a_sclk,  0);
    chk("mid rst mosi",  a_mosi,  0);
    chk("mid rst ready", a_ready, 1);
    chk("mid rst done",  a_done,  0);
    a_reset = 1'b0; t1 = cyc;
    step(1);
    chk("post rst cs_n", a_cs_n, 0);
    a_valid = 1'b0;
    go_to(t1 + 70);
    chk("rst accepts", aq_a.size(), 2);
    if (aq_a.size() == 2) chk("rst accept cyc", aq_a[1] - aq_a[0], 21);
    chk("rst frames", fq_a.size(), 2);
    if (fq_a.size() == 2) begin
      chk("partial rises", fq_a[0].rises, 5);
      chk("partial done", fq_a[0].done, 0);
      chk("after rst data", fq_a[1].dat, 16'h3777);
      chk("after rst rises", fq_a[1].rises, 16);
      chk("after rst done", fq_a[1].done, 1);
    end

    // Fast instance: CLK_DIV=1, GAP_CYCLES=1, CONFIG=F.
    b_sample = 12'h555; b_valid = 1'b1;
    wait_rdy(1'b1, t0);
    step(1);
    b_sample = 12'hAAA;
    chk("fast t1 sclk", b_sclk, 0);
    chk("fast t1 mosi", b_mosi, 1);
    step(1); chk("fast t2 sclk", b_sclk, 1);
    step(1); chk("fast t3 sclk", b_sclk, 0);
    go_to(t0 + 34); chk("fast t34 cs_n", b_cs_n, 1); chk("fast t34 done", b_done, 1);
    wait_rdy(1'b1, t1);
    chk("fast period", t1 - t0, 35);
    step(1);
    b_valid = 1'b0;
    go_to(t1 + 36);
    chk("fast frames", fq_b.size(), 2);
    if (fq_b.size() == 2) begin
      chk("fast data0", fq_b[0].dat, 16'hF555);
      chk("fast data1", fq_b[1].dat, 16'hFAAA);
      chk("fast rises0", fq_b[0].rises, 16);
      chk("fast rises1", fq_b[1].rises, 16);
      chk("fast cs low", fq_b[0].low, 33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout want finish)");
    $fatal(1);
  end

endmodule
